cmplt_arbiter: RTL and testbench

- Schedules completion traffic from the execution pipelines (arithmetic result, arithmetic flags, memory, terminate) onto the limited physical-register-file write / ROB-complete ports.
- Each requester gets a small skid FIFO with a ready/valid handshake.
- A round-robin arbiter grants up to NUM_PORTS heads per cycle into registered completion ports.
- Sits between the middle-end pipelines and the register file's write_addrs/write_vals inputs and the ROB completion inputs.

---
 rtl/cmplt_arbiter_pkg.sv | 14 +
 rtl/cmplt_fifo.sv | 51 +++++
 rtl/cmplt_arbiter.sv | 115 +++++++++++
 tb/tb_cmplt_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmplt_arbiter_pkg.sv
// Shared widths and source indices for the completion arbiter.
package cmplt_arbiter_pkg;
  localparam int PREG_W = 5;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 8;
  localparam int SRC_W  = 2;

  typedef enum logic [SRC_W-1:0] {
    SRC_ARITH = 2'd0,
    SRC_FLAGS = 2'd1,
    SRC_MEM   = 2'd2,
    SRC_TERM  = 2'd3
  } src_e;
endpackage

// File: rtl/cmplt_fifo.sv
// Per-source skid FIFO; count is registered so ready never sees the same-cycle pop.
module cmplt_fifo
  import cmplt_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push && (count < (AW+1)'(DEPTH)) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cmplt_arbiter.sv
// Round-robin scheduler of pipeline completions onto NUM_PORTS registered completion ports.
module cmplt_arbiter
  import cmplt_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 2,
  parameter int PREG_W    = cmplt_arbiter_pkg::PREG_W,
  parameter int ROB_W     = cmplt_arbiter_pkg::ROB_W,
  parameter int DATA_W    = cmplt_arbiter_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC*ROB_W-1:0]    src_rob,
  input  logic [NUM_SRC*PREG_W-1:0]   src_preg,
  input  logic [NUM_SRC*DATA_W-1:0]   src_val,
  input  logic [NUM_SRC-1:0]          src_wr,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_PORTS-1:0]        cmplt_valid,
  output logic [NUM_PORTS*ROB_W-1:0]  cmplt_rob,
  output logic [NUM_PORTS*PREG_W-1:0] cmplt_reg,
  output logic [NUM_PORTS*DATA_W-1:0] cmplt_val,
  output logic [NUM_PORTS-1:0]        cmplt_wr,
  output logic [NUM_PORTS-1:0]        cmplt_last,
  output logic [NUM_PORTS*2-1:0]      cmplt_src
);
  localparam int EW = ROB_W + PREG_W + DATA_W + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_SRC-1:0][EW-1:0]     din, head;
  logic [NUM_SRC-1:0][CW-1:0]     count;
  logic [NUM_SRC-1:0]             nonempty, grant, push;
  logic [SRC_W-1:0]               rr_ptr, rr_next;
  logic [NUM_PORTS-1:0][SRC_W-1:0] port_src, src_q;
  logic [NUM_PORTS-1:0]           port_vld, vld_q;
  logic [NUM_PORTS-1:0][EW-1:0]   out_d, out_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign din[g] = {src_rob[g*ROB_W +: ROB_W], src_preg[g*PREG_W +: PREG_W],
                     src_val[g*DATA_W +: DATA_W], src_wr[g], src_last[g]};
    assign src_ready[g] = count[g] < CW'(DEPTH);
    assign nonempty[g]  = count[g] != '0;
    assign push[g]      = src_valid[g] & src_ready[g];

    cmplt_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .pop   (grant[g]),
      .din   (din[g]),
      .dout  (head[g]),
      .count (count[g])
    );
  end

  // Scan from rr_ptr; grants fill ports in scan order.
  always_comb begin
    int n;
    int idx;
    grant    = '0;
    port_src = '0;
    port_vld = '0;
    rr_next  = rr_ptr;
    n        = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (nonempty[idx] && n < NUM_PORTS) begin
        grant[idx]  = 1'b1;
        port_src[n] = SRC_W'(idx);
        port_vld[n] = 1'b1;
        rr_next     = SRC_W'((idx + 1) % NUM_SRC);
        n++;
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (port_vld[p]) out_d[p] = head[port_src[p]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      vld_q  <= '0;
      src_q  <= '0;
      out_q  <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
      vld_q  <= '0;
      src_q  <= '0;
      out_q  <= '0;
    end else begin
      rr_ptr <= rr_next;
      vld_q  <= port_vld;
      src_q  <= port_src;
      out_q  <= out_d;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign cmplt_valid[p]               = vld_q[p];
    assign cmplt_rob[p*ROB_W +: ROB_W]  = out_q[p][EW-1 -: ROB_W];
    assign cmplt_reg[p*PREG_W +: PREG_W] = out_q[p][DATA_W+2 +: PREG_W];
    assign cmplt_val[p*DATA_W +: DATA_W] = out_q[p][2 +: DATA_W];
    assign cmplt_wr[p]                  = out_q[p][1];
    assign cmplt_last[p]                = out_q[p][0];
    assign cmplt_src[p*2 +: 2]          = 2'(src_q[p]);
  end
endmodule

// File: tb/tb_cmplt_arbiter.sv
// Directed bench for cmplt_arbiter with hand-computed expectations.
module tb_cmplt_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] src_valid = '0;
  logic [3:0] src_ready;
  logic [19:0] src_rob = '0;
  logic [19:0] src_preg = '0;
  logic [31:0] src_val = '0;
  logic [3:0] src_wr = '0;
  logic [3:0] src_last = '0;
  logic [1:0] cmplt_valid;
  logic [9:0] cmplt_rob;
  logic [9:0] cmplt_reg;
  logic [15:0] cmplt_val;
  logic [1:0] cmplt_wr;
  logic [1:0] cmplt_last;
  logic [3:0] cmplt_src;

  int pass_cnt = 0;
  int total_cnt = 0;

  cmplt_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_rob(src_rob), .src_preg(src_preg), .src_val(src_val),
    .src_wr(src_wr), .src_last(src_last),
    .cmplt_valid(cmplt_valid), .cmplt_rob(cmplt_rob), .cmplt_reg(cmplt_reg),
    .cmplt_val(cmplt_val), .cmplt_wr(cmplt_wr), .cmplt_last(cmplt_last),
    .cmplt_src(cmplt_src)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] rob, input logic [4:0] preg,
                         input logic [7:0] val, input logic wr, input logic last);
    src_valid[i]         = 1'b1;
    src_rob[i*5 +: 5]    = rob;
    src_preg[i*5 +: 5]   = preg;
    src_val[i*8 +: 8]    = val;
    src_wr[i]            = wr;
    src_last[i]          = last;
  endtask

  task automatic clr_src;
    src_valid = '0;
  endtask

  task automatic do_flush;
    clr_src();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    total_cnt++;
    if (cmplt_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", cmplt_valid); else pass_cnt++;
    total_cnt++;
    if (cmplt_rob !== 10'd0 || cmplt_src !== 4'd0) $display("FAIL reset_fields: rob %h src %h want 0", cmplt_rob, cmplt_src); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (src_ready !== 4'hF) $display("FAIL reset_ready: got %b want 1111", src_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_single;
    do_flush();
    set_src(2, 5'd3, 5'd17, 8'hA5, 1'b1, 1'b1);
    step();
    clr_src();
    total_cnt++;
    if (cmplt_valid !== 2'b00) $display("FAIL single_early: got %b want 00", cmplt_valid); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_src[1:0] !== 2'd2)
      $display("FAIL single_valid: valid %b src %0d want 01 src 2", cmplt_valid, cmplt_src[1:0]); else pass_cnt++;
    total_cnt++;
    if (cmplt_rob[4:0] !== 5'd3 || cmplt_reg[4:0] !== 5'd17 || cmplt_val[7:0] !== 8'hA5)
      $display("FAIL single_fields: rob %0d reg %0d val %h want 3 17 a5", cmplt_rob[4:0], cmplt_reg[4:0], cmplt_val[7:0]); else pass_cnt++;
    total_cnt++;
    if (cmplt_wr !== 2'b01 || cmplt_last !== 2'b01)
      $display("FAIL single_strobes: wr %b last %b want 01 01", cmplt_wr, cmplt_last); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b00) $display("FAIL single_one_cycle: got %b want 00", cmplt_valid); else pass_cnt++;
  endtask

  task automatic test_all4;
    do_flush();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 1), 5'(i + 4), 8'(8'h10 + i), 1'b1, 1'b1);
    step();
    clr_src();
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b11 || cmplt_src !== 4'b0100 || cmplt_rob !== {5'd2, 5'd1})
      $display("FAIL all4_cycA: valid %b src %b rob %h want 11 0100 %h", cmplt_valid, cmplt_src, cmplt_rob, {5'd2, 5'd1}); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b11 || cmplt_src !== 4'b1110 || cmplt_rob !== {5'd4, 5'd3})
      $display("FAIL all4_cycB: valid %b src %b rob %h want 11 1110 %h", cmplt_valid, cmplt_src, cmplt_rob, {5'd4, 5'd3}); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b00) $display("FAIL all4_drain: got %b want 00", cmplt_valid); else pass_cnt++;
    // rr_ptr back at 0: src 0 must take port 0 ahead of src 3
    set_src(0, 5'd5, 5'd1, 8'h01, 1'b1, 1'b1);
    set_src(3, 5'd6, 5'd2, 8'h02, 1'b1, 1'b1);
    step();
    clr_src();
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b11 || cmplt_src !== 4'b1100)
      $display("FAIL all4_rr_wrap: valid %b src %b want 11 1100", cmplt_valid, cmplt_src); else pass_cnt++;
    step();
  endtask

  task automatic test_full;
    do_flush();
    set_src(0, 5'd20, 5'd1, 8'h00, 1'b1, 1'b1);
    step();
    clr_src();
    set_src(0, 5'd1, 5'd1, 8'h01, 1'b1, 1'b1);
    set_src(1, 5'd10, 5'd2, 8'h02, 1'b1, 1'b1);
    set_src(2, 5'd11, 5'd3, 8'h03, 1'b1, 1'b1);
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_rob[4:0] !== 5'd20)
      $display("FAIL full_first: valid %b rob %0d want 01 20", cmplt_valid, cmplt_rob[4:0]); else pass_cnt++;
    clr_src();
    set_src(0, 5'd2, 5'd1, 8'h04, 1'b1, 1'b1);
    set_src(3, 5'd12, 5'd4, 8'h05, 1'b1, 1'b1);
    step();
    total_cnt++;
    if (src_ready[0] !== 1'b0) $display("FAIL full_ready_low: got %b want 0", src_ready[0]); else pass_cnt++;
    total_cnt++;
    if (cmplt_src !== 4'b1001 || cmplt_rob !== {5'd11, 5'd10})
      $display("FAIL full_others: src %b rob %h want 1001 %h", cmplt_src, cmplt_rob, {5'd11, 5'd10}); else pass_cnt++;
    clr_src();
    set_src(0, 5'd3, 5'd1, 8'h06, 1'b1, 1'b1);
    step();
    total_cnt++;
    if (cmplt_src !== 4'b0011 || cmplt_rob !== {5'd1, 5'd12})
      $display("FAIL full_pop: src %b rob %h want 0011 %h", cmplt_src, cmplt_rob, {5'd1, 5'd12}); else pass_cnt++;
    total_cnt++;
    if (src_ready[0] !== 1'b1) $display("FAIL full_ready_back: got %b want 1", src_ready[0]); else pass_cnt++;
    step();
    clr_src();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_rob[4:0] !== 5'd2)
      $display("FAIL full_second: valid %b rob %0d want 01 2", cmplt_valid, cmplt_rob[4:0]); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_rob[4:0] !== 5'd3)
      $display("FAIL full_held: valid %b rob %0d want 01 3", cmplt_valid, cmplt_rob[4:0]); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b00) $display("FAIL full_empty: got %b want 00", cmplt_valid); else pass_cnt++;
  endtask

  task automatic test_push_pop;
    do_flush();
    set_src(1, 5'd7, 5'd9, 8'h77, 1'b1, 1'b1);
    step();
    set_src(1, 5'd8, 5'd10, 8'h88, 1'b1, 1'b1);
    step();
    clr_src();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_rob[4:0] !== 5'd7 || src_ready[1] !== 1'b1)
      $display("FAIL pp_first: valid %b rob %0d ready %b want 01 7 1", cmplt_valid, cmplt_rob[4:0], src_ready[1]); else pass_cnt++;
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_rob[4:0] !== 5'd8 || cmplt_val[7:0] !== 8'h88)
      $display("FAIL pp_second: valid %b rob %0d val %h want 01 8 88", cmplt_valid, cmplt_rob[4:0], cmplt_val[7:0]); else pass_cnt++;
    step();
  endtask

  task automatic test_term;
    do_flush();
    set_src(3, 5'd9, 5'd6, 8'h33, 1'b0, 1'b1);
    step();
    clr_src();
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b01 || cmplt_wr !== 2'b00 || cmplt_last !== 2'b01 || cmplt_rob[4:0] !== 5'd9 || cmplt_src[1:0] !== 2'd3)
      $display("FAIL term: valid %b wr %b last %b rob %0d src %0d want 01 00 01 9 3",
               cmplt_valid, cmplt_wr, cmplt_last, cmplt_rob[4:0], cmplt_src[1:0]); else pass_cnt++;
    step();
  endtask

  task automatic test_flush;
    do_flush();
    for (int i = 0; i < 3; i++) set_src(i, 5'(i + 13), 5'(i), 8'(i), 1'b1, 1'b1);
    step();
    clr_src();
    set_src(3, 5'd16, 5'd3, 8'h03, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clr_src();
    total_cnt++;
    if (cmplt_valid !== 2'b00 || src_ready !== 4'hF)
      $display("FAIL flush_now: valid %b ready %b want 00 1111", cmplt_valid, src_ready); else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (cmplt_valid !== 2'b00) $display("FAIL flush_stale: cycle %0d valid %b want 00", c, cmplt_valid); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    do_flush();
    for (int i = 0; i < 4; i++) set_src(i, 5'(i + 21), 5'(i), 8'(i), 1'b1, 1'b1);
    step();
    clr_src();
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b11) $display("FAIL arst_pre: got %b want 11", cmplt_valid); else pass_cnt++;
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (cmplt_valid !== 2'b00 || cmplt_rob !== 10'd0)
      $display("FAIL arst_async: valid %b rob %h want 00 000", cmplt_valid, cmplt_rob); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    total_cnt++;
    if (cmplt_valid !== 2'b00 || src_ready !== 4'hF)
      $display("FAIL arst_lost: valid %b ready %b want 00 1111", cmplt_valid, src_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_full();
    test_push_pop();
    test_term();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
